rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 123 ++++++++++++
 tb/tb_rr_arb_mux.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Registered N-channel arbiter/mux: fixed-select or round-robin grant
// into a single output register with valid/ready handshakes.
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic [SELW-1:0]  outCh;
  logic [SELW-1:0]  rrPtr;

  logic             canLoad;
  logic             load;
  logic             fixedHit;
  logic             rrHit;
  logic             grantValid;
  logic [SELW-1:0]  rrIdx;
  logic [SELW-1:0]  grantIdx;
  logic [SELW-1:0]  nextPtr;
  logic [WIDTH-1:0] payload;
  logic [NCH-1:0]   readyVec;

  // An out-of-range sel simply never matches, so it yields no grant.
  always_comb begin
    fixedHit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i) && in_valid[i]) begin
        fixedHit = 1'b1;
      end
    end
  end

  // Walk offsets high to low so the nearest valid channel wins.
  always_comb begin
    int idx;
    logic [SELW-1:0] idxW;
    rrHit = 1'b0;
    rrIdx = '0;
    idx = 0;
    idxW = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(rrPtr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      idxW = SELW'(idx);
      if (in_valid[idxW]) begin
        rrHit = 1'b1;
        rrIdx = idxW;
      end
    end
  end

  always_comb begin
    grantValid = 1'b0;
    grantIdx = '0;
    unique case (1'b1)
      mode: begin
        grantValid = rrHit;
        grantIdx = rrIdx;
      end
      default: begin
        grantValid = fixedHit;
        grantIdx = sel;
      end
    endcase
  end

  assign canLoad = !outValid || out_ready;
  assign load = rst_n && canLoad && grantValid;

  always_comb begin
    readyVec = '0;
    payload = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grantIdx == SELW'(i)) begin
        readyVec[i] = load;
        payload = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign nextPtr = (grantIdx == SELW'(NCH - 1)) ?
                   '0 : grantIdx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outData <= '0;
      outCh <= '0;
      rrPtr <= '0;
    end else if (load) begin
      outValid <= 1'b1;
      outData <= payload;
      outCh <= grantIdx;
      if (mode) begin
        rrPtr <= nextPtr;
      end
    end else if (out_ready) begin
      outValid <= 1'b0;
    end
  end

  assign in_ready = readyVec;
  assign out_valid = outValid;
  assign out_data = outData;
  assign out_ch = outCh;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: vector table, directed corner sequences and
// randomized traffic against a queue-free behavioural model.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [63:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inReady;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic [1:0]  outCh;

  logic [23:0] d3InData;
  logic [2:0]  d3InValid;
  logic [2:0]  d3InReady;
  logic        d3Mode;
  logic [1:0]  d3Sel;
  logic [7:0]  d3OutData;
  logic        d3OutValid;
  logic        d3OutReady;
  logic [1:0]  d3OutCh;

  int checks;
  int errors;

  rr_arb_mux #(.WIDTH(16), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(inData), .in_valid(inValid),
    .in_ready(inReady), .mode(mode), .sel(sel),
    .out_data(outData), .out_valid(outValid),
    .out_ready(outReady), .out_ch(outCh)
  );

  rr_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d3InData), .in_valid(d3InValid),
    .in_ready(d3InReady), .mode(d3Mode), .sel(d3Sel),
    .out_data(d3OutData), .out_valid(d3OutValid),
    .out_ready(d3OutReady), .out_ch(d3OutCh)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [3:0] v;
    logic [3:0] expReady;
    logic       expValid;
    logic [1:0] expCh;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant as stated by the rules: fixed index, or first valid
  // channel scanning upward from the pointer with wrap.
  function automatic int gold(input logic m, input logic [1:0] s,
                              input logic [3:0] v, input int ptr);
    int c;
    if (!m) return v[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++) begin
      c = (ptr + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    inValid = '0;
    d3InValid = '0;
    #1;
    chk("rst_valid", 32'(outValid), 0);
    chk("rst_data", 32'(outData), 0);
    chk("rst_ch", 32'(outCh), 0);
    chk("rst_ready", 32'(inReady), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int cnt;
  int g;
  logic [3:0] expRdy;
  logic mValid;
  logic [15:0] mData;
  logic [1:0] mCh;
  int mPtr;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    inData = '0;
    inValid = '0;
    mode = 1'b0;
    sel = '0;
    outReady = 1'b1;
    d3InData = '0;
    d3InValid = '0;
    d3Mode = 1'b0;
    d3Sel = '0;
    d3OutReady = 1'b1;

    tbl[0] = '{1'b0, 2'd1, 4'b1101, 4'b0000, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 2'd2};
    tbl[2] = '{1'b0, 2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3};
    tbl[3] = '{1'b0, 2'd0, 4'b1110, 4'b0000, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 2'd0, 4'b1010, 4'b0010, 1'b1, 2'd1};
    tbl[5] = '{1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3};
    tbl[7] = '{1'b1, 2'd0, 4'b1111, 4'b0001, 1'b1, 2'd0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    inData = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      resetDut();
      mode = tbl[i].m;
      sel = tbl[i].s;
      inValid = tbl[i].v;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(inReady),
          32'(tbl[i].expReady));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(outValid),
          32'(tbl[i].expValid));
      if (tbl[i].expValid) begin
        chk($sformatf("tbl%0d_ch", i), 32'(outCh),
            32'(tbl[i].expCh));
        chk($sformatf("tbl%0d_data", i), 32'(outData),
            32'(16'h1000 + 16'(tbl[i].expCh)));
      end
    end

    // Full-rate round robin from reset.
    resetDut();
    mode = 1'b1;
    inValid = 4'b1111;
    inData = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    outReady = 1'b1;
    #1;
    chk("rr_first_ready", 32'(inReady), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("rr_ch", 32'(outCh), 32'(k % 4));
      chk("rr_data", 32'(outData), 32'(16'h000A + 16'(k % 4)));
      chk("rr_valid", 32'(outValid), 1);
      chk("rr_ready", 32'(inReady), 32'(4'b1 << ((k + 1) % 4)));
    end

    // Reset while holding a word; round robin restarts at ch0.
    @(negedge clk);
    outReady = 1'b0;
    @(posedge clk);
    #2;
    chk("hold_before_rst", 32'(outValid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(outValid), 0);
    chk("async_rst_data", 32'(outData), 0);
    chk("async_rst_ready", 32'(inReady), 0);
    @(negedge clk);
    rst_n = 1'b1;
    outReady = 1'b1;
    #1;
    chk("post_rst_ready", 32'(inReady), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_ch", 32'(outCh), 0);

    // Pointer at 2 after a lone ch1 transfer, then 1010 alternates.
    resetDut();
    mode = 1'b1;
    inValid = 4'b0010;
    @(posedge clk);
    #1;
    chk("ptr_setup_ch", 32'(outCh), 1);
    @(negedge clk);
    inValid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("alt_onehot", 32'($countones(inReady) <= 1), 1);
      chk("alt_ready", 32'(inReady),
          (k % 2 == 0) ? 32'h8 : 32'h2);
      @(posedge clk);
      #1;
      chk("alt_ch", 32'(outCh), (k % 2 == 0) ? 3 : 1);
      @(negedge clk);
    end

    // Backpressure hold, then exactly one output transfer.
    resetDut();
    mode = 1'b0;
    sel = 2'd2;
    inData = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    inValid = 4'b0100;
    outReady = 1'b0;
    #1;
    chk("bp_ready0", 32'(inReady), 32'h4);
    @(negedge clk);
    inValid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      mode = ~mode;
      sel = 2'(k);
      #1;
      chk("bp_data", 32'(outData), 32'hBEEF);
      chk("bp_valid", 32'(outValid), 1);
      chk("bp_ch", 32'(outCh), 2);
      chk("bp_ready", 32'(inReady), 0);
      @(negedge clk);
    end
    mode = 1'b0;
    outReady = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (outValid && outReady) cnt++;
      @(negedge clk);
    end
    chk("bp_accept_once", 32'(cnt), 1);

    // Three-channel instance: wrap order and out-of-range sel.
    resetDut();
    d3Mode = 1'b0;
    d3Sel = 2'd3;
    d3InValid = 3'b111;
    d3InData = {8'h33, 8'h22, 8'h11};
    #1;
    chk("n3_badsel_ready", 32'(d3InReady), 0);
    @(posedge clk);
    #1;
    chk("n3_badsel_valid", 32'(d3OutValid), 0);
    @(negedge clk);
    d3Mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("n3_ch", 32'(d3OutCh), 32'(k % 3));
      chk("n3_data", 32'(d3OutData),
          32'(8'h11 * 8'((k % 3) + 1)));
    end
    @(negedge clk);
    d3InValid = '0;

    // Random traffic against the behavioural model.
    resetDut();
    mValid = 1'b0;
    mData = '0;
    mCh = '0;
    mPtr = 0;
    for (int n = 0; n < 1500; n++) begin
      inValid = 4'($urandom);
      inData = {$urandom, $urandom};
      outReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom);
      #1;
      g = gold(mode, sel, inValid, mPtr);
      expRdy = '0;
      if ((!mValid || outReady) && g >= 0) expRdy[g] = 1'b1;
      chk("rnd_ready", 32'(inReady), 32'(expRdy));
      chk("rnd_valid", 32'(outValid), 32'(mValid));
      if (mValid) begin
        chk("rnd_data", 32'(outData), 32'(mData));
        chk("rnd_ch", 32'(outCh), 32'(mCh));
      end
      if (expRdy != 0) begin
        mValid = 1'b1;
        mData = inData[g*16 +: 16];
        mCh = 2'(g);
        if (mode) mPtr = (g + 1) % 4;
      end else if (outReady) begin
        mValid = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
